// File: rtl/seq_tx101.sv
// -----------------------------------------------------------------------------
// seq_tx101 -- framed serial transmitter (Moore FSM)
//
// Sends one frame per accepted request on a single serial line:
//   preamble 1,0,1 -> DATA_W payload bits MSB first -> [even parity] -> gap 0
// A request (Start) is accepted only while Ready is high. The payload is
// latched on the accepting edge and held for the whole frame.
//
// Optional feature macro: SEQ_TX101_PARITY_EN
//   defined   : one PAR cycle carrying even parity of the payload follows DATA
//   undefined : DATA goes straight to GAP; no parity state or logic is built
//
// Parameters
//   DATA_W  payload bits per frame (2..32)
//
// Ports
//   Clk    in   sole clock, rising edge
//   Rst    in   synchronous active-high reset, wins over Start
//   Start  in   frame request, sampled only while Ready=1
//   Data   in   payload, captured on the accepting edge
//   Ready  out  high only in IDLE
//   Busy   out  high from the first preamble bit through GAP
//   Done   out  one-cycle pulse during GAP
//   Dout   out  serial line, idles at 0
//
// All outputs are flops computed from the next state, so they carry the value
// belonging to the state being entered, with no path from Start/Data.
// -----------------------------------------------------------------------------
module seq_tx101 #(
    parameter int DATA_W = 8
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic [DATA_W-1:0] Data,
    output logic              Ready,
    output logic              Busy,
    output logic              Done,
    output logic              Dout
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

`ifdef SEQ_TX101_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE1 = 3'd1,
        S_PRE0 = 3'd2,
        S_PRE2 = 3'd3,
        S_DATA = 3'd4,
        S_GAP  = 3'd5,
        S_PAR  = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE1 = 3'd1,
        S_PRE0 = 3'd2,
        S_PRE2 = 3'd3,
        S_DATA = 3'd4,
        S_GAP  = 3'd5
    } state_t;
`endif

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               ready_q, ready_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;
    logic               dout_q,  dout_d;
`ifdef SEQ_TX101_PARITY_EN
    logic               par_q,   par_d;
`endif

    // Next-state and next-datapath logic
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
`ifdef SEQ_TX101_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d = S_PRE1;
                    shreg_d = Data;
                    cnt_d   = CNT_W'(DATA_W - 1);
`ifdef SEQ_TX101_PARITY_EN
                    par_d   = ^Data;
`endif
                end
            end
            S_PRE1: state_d = S_PRE0;
            S_PRE0: state_d = S_PRE2;
            S_PRE2: state_d = S_DATA;
            S_DATA: begin
                // The MSB on the line this cycle is consumed; the shift on the
                // final bit is harmless since the register is reloaded before use.
                shreg_d = shreg_q << 1;
                if (cnt_q == '0) begin
`ifdef SEQ_TX101_PARITY_EN
                    state_d = S_PAR;
`else
                    state_d = S_GAP;
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`ifdef SEQ_TX101_PARITY_EN
            S_PAR:  state_d = S_GAP;
`endif
            S_GAP:  state_d = S_IDLE;
            // Any unused encoding recovers to IDLE on the next edge.
            default: state_d = S_IDLE;
        endcase
    end

    // Registered outputs derived from the state being entered
    always_comb begin
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_GAP);
        dout_d  = 1'b0;
        case (state_d)
            S_PRE1: dout_d = 1'b1;
            S_PRE2: dout_d = 1'b1;
            S_DATA: dout_d = shreg_d[DATA_W-1];
`ifdef SEQ_TX101_PARITY_EN
            S_PAR:  dout_d = par_d;
`endif
            default: dout_d = 1'b0;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
`ifdef SEQ_TX101_PARITY_EN
            par_q   <= 1'b0;
`endif
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
`ifdef SEQ_TX101_PARITY_EN
            par_q   <= par_d;
`endif
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dout_q  <= dout_d;
        end
    end

    assign Ready = ready_q;
    assign Busy  = busy_q;
    assign Done  = done_q;
    assign Dout  = dout_q;

endmodule

// File: tb/tb_seq_tx101.sv
// -----------------------------------------------------------------------------
// Directed testbench for seq_tx101 (DATA_W=8). Expected line patterns are
// written out by hand; the parity variants are selected by the same macro
// that configures the design.
// Cycle k is the clock period following the k-th edge after a request edge.
// -----------------------------------------------------------------------------
module tb_seq_tx101;

    logic       Clk;
    logic       Rst;
    logic       Start;
    logic [7:0] Data;
    logic       Ready;
    logic       Busy;
    logic       Done;
    logic       Dout;

    int n_chk = 0;
    int n_err = 0;
    int done_cnt = 0;
    int done_ref;

    seq_tx101 #(.DATA_W(8)) dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .Start (Start),
        .Data  (Data),
        .Ready (Ready),
        .Busy  (Busy),
        .Done  (Done),
        .Dout  (Dout)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Count completed frames from the Done pulse.
    always @(negedge Clk) if (Done === 1'b1) done_cnt++;

`ifdef SEQ_TX101_PARITY_EN
    localparam int FLEN = 13;
    // preamble, payload, parity, gap
    localparam logic [15:0] EXP_A5 = 16'b101_10100101_0_0;
    localparam logic [15:0] EXP_07 = 16'b101_00000111_1_0;
    localparam logic [15:0] EXP_FF = 16'b101_11111111_0_0;
    localparam logic [15:0] EXP_00 = 16'b101_00000000_0_0;
`else
    localparam int FLEN = 12;
    // preamble, payload, gap
    localparam logic [15:0] EXP_A5 = 16'b0000_101_10100101_0;
    localparam logic [15:0] EXP_07 = 16'b0000_101_00000111_0;
    localparam logic [15:0] EXP_FF = 16'b0000_101_11111111_0;
    localparam logic [15:0] EXP_00 = 16'b0000_101_00000000_0;
`endif

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".ready"}, 32'(Ready), 32'd1);
        chk({tag, ".busy"},  32'(Busy),  32'd0);
        chk({tag, ".done"},  32'(Done),  32'd0);
        chk({tag, ".dout"},  32'(Dout),  32'd0);
    endtask

    // Checks frame cycles first+1 .. FLEN (currently sitting in cycle first+1),
    // then the IDLE cycle that follows GAP.
    task automatic run_frame(input string tag, input logic [15:0] exp, input int first);
        logic [15:0] e;
        e = exp;
        for (int i = first; i < FLEN; i++) begin
            chk($sformatf("%s.dout[c%0d]", tag, i + 1), 32'(Dout), 32'(e[FLEN-1-i]));
            chk($sformatf("%s.busy[c%0d]", tag, i + 1), 32'(Busy), 32'd1);
            chk($sformatf("%s.ready[c%0d]", tag, i + 1), 32'(Ready), 32'd0);
            chk($sformatf("%s.done[c%0d]", tag, i + 1), 32'(Done), 32'(i == FLEN - 1));
            step();
        end
        chk_idle({tag, ".after"});
    endtask

    initial begin
        Rst   = 1'b1;
        Start = 1'b0;
        Data  = 8'h00;
        step();
        step();
        Rst = 1'b0;
        chk_idle("reset");
        step();
        chk_idle("reset_hold");

        // Basic frame; Data changed right after acceptance must not matter.
        done_ref = done_cnt;
        Start = 1'b1;
        Data  = 8'hA5;
        step();
        Start = 1'b0;
        Data  = 8'h3C;
        run_frame("frame_a5", EXP_A5, 0);
        chk("frame_a5.done_cnt", 32'(done_cnt), 32'(done_ref + 1));

        // Payload with odd ones count (parity 1 when enabled).
        Start = 1'b1;
        Data  = 8'h07;
        step();
        Start = 1'b0;
        Data  = 8'h00;
        run_frame("frame_07", EXP_07, 0);

        // Start held high: back-to-back frames separated by exactly one IDLE.
        done_ref = done_cnt;
        Start = 1'b1;
        Data  = 8'hFF;
        step();
        Data  = 8'h00;
        run_frame("hold_ff", EXP_FF, 0);
        step();
        Start = 1'b0;
        Data  = 8'hFF;
        run_frame("hold_00", EXP_00, 0);
        chk("hold.done_cnt", 32'(done_cnt), 32'(done_ref + 2));

        // Reset during the fourth payload bit (cycle 7) aborts without Done.
        done_ref = done_cnt;
        Start = 1'b1;
        Data  = 8'hA5;
        step();
        Start = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("abort.busy_before", 32'(Busy), 32'd1);
        chk("abort.dout_bit3",   32'(Dout), 32'd0);
        Rst = 1'b1;
        step();
        Rst = 1'b0;
        chk_idle("abort");
        for (int i = 0; i < 15; i++) step();
        chk_idle("abort_later");
        chk("abort.done_cnt", 32'(done_cnt), 32'(done_ref));

        // Rst and Start on the same edge: reset wins.
        Rst   = 1'b1;
        Start = 1'b1;
        Data  = 8'hFF;
        step();
        Rst   = 1'b0;
        Start = 1'b0;
        chk_idle("rst_start");
        step();
        chk_idle("rst_start_next");

        // Start pulse while busy is ignored and nothing is queued.
        done_ref = done_cnt;
        Start = 1'b1;
        Data  = 8'h07;
        step();
        Start = 1'b0;
        Data  = 8'h00;
        for (int i = 0; i < 4; i++) step();
        Start = 1'b1;
        Data  = 8'hFF;
        step();
        Start = 1'b0;
        Data  = 8'h00;
        run_frame("busy_start", EXP_07, 5);
        for (int i = 0; i < 5; i++) begin
            step();
            chk_idle($sformatf("busy_start.idle%0d", i));
        end
        chk("busy_start.done_cnt", 32'(done_cnt), 32'(done_ref + 1));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/seq_tx101.md
SEQ_TX101 -- requirements
Module: seq_tx101

Interface
REQ-001 SHALL have parameter DATA_W, default 8, payload bits per frame (legal 2..32).
REQ-002 SHALL have port Clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port Rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port Start  input  1  frame request; sampled only while Ready=1.
REQ-005 SHALL have port Data  input  DATA_W  payload; captured on the edge that accepts Start.
REQ-006 SHALL have port Ready  output  1  high only in IDLE.
REQ-007 SHALL have port Busy  output  1  high from the first preamble bit through GAP inclusive.
REQ-008 SHALL have port Done  output  1  one-cycle pulse during GAP of a completed frame.
REQ-009 SHALL have port Dout  output  1  serial line output; idle level 0.

Function
REQ-010 SHALL be a Moore FSM with states IDLE, PRE1, PRE0, PRE2, DATA, PAR (macro-dependent), GAP.
REQ-011 SHALL drive Dout, Ready, Busy and Done from registered state only, with no combinational path from Start or Data.
REQ-012 SHALL map Dout as IDLE=0, PRE1=1, PRE0=0, PRE2=1, DATA=shift-register MSB, PAR=parity bit, GAP=0.
REQ-013 SHALL transition IDLE->PRE1 on an edge where Start=1, latching Data into the shift register and loading the bit counter with DATA_W-1.
REQ-014 SHALL step PRE1->PRE0->PRE2->DATA unconditionally, one cycle each.
REQ-015 SHALL hold DATA for exactly DATA_W cycles, sending payload MSB first.
REQ-016 SHALL, in DATA, left-shift the register and decrement the counter each cycle, leaving DATA when the counter is 0.
REQ-017 SHALL hold GAP for exactly one cycle, then return to IDLE.
REQ-018 SHALL put the first preamble bit on Dout in the cycle immediately after the accepting edge (latency 1).
REQ-019 SHALL ignore Start and Data whenever Ready=0; no queuing.
REQ-020 SHALL stay in IDLE for at least one cycle between frames. With Start held high, consecutive frames are separated by GAP plus one IDLE cycle.
REQ-021 SHALL keep the latched payload stable for the whole frame regardless of later changes on Data.
REQ-022 SHALL send any state-register value outside the legal encodings to IDLE on the next edge.

Reset
REQ-023 SHALL, on an edge with Rst=1, enter IDLE, clear the shift register, counter and parity register, and produce Ready=1, Busy=0, Done=0, Dout=0 from the following cycle.
REQ-024 SHALL give Rst priority over Start on the same edge.
REQ-025 SHALL abort a frame on Rst asserted mid-frame, with no Done pulse for that frame.

Configuration
REQ-026 SHALL, with macro SEQ_TX101_PARITY_EN defined, insert state PAR between DATA and GAP for one cycle.
REQ-027 SHALL, in PAR, send an even-parity bit equal to the XOR of the latched payload, making the total number of ones in payload plus parity even.
REQ-028 SHALL, without SEQ_TX101_PARITY_EN, omit PAR and its parity logic, with DATA going directly to GAP.
REQ-029 SHALL have a frame length of 3+DATA_W+1 cycles without parity and 3+DATA_W+2 cycles with parity.

Verification
REQ-030 SHALL cover: DATA_W=8, no parity, Data=8'hA5, Start pulsed for 1 cycle -> Dout 1,0,1,1,0,1,0,0,1,0,1 then 0 (GAP); Done high only in GAP cycle 12; Ready=1 in cycle 13.
REQ-031 SHALL cover: parity enabled, Data=8'h07 -> Dout 1,0,1,0,0,0,0,0,1,1,1, parity 1, then 0; Done in cycle 13.
REQ-032 SHALL cover: Start held high, Data=8'hFF then 8'h00 -> second frame PRE1 starts exactly one IDLE cycle after GAP; Data changes mid-frame do not affect Dout.
REQ-033 SHALL cover: Rst asserted during DATA bit 3 -> next cycle IDLE, Dout=0, Ready=1, Busy=0; no Done for the aborted frame.
REQ-034 SHALL cover: Start=1 and Rst=1 on the same edge -> stays IDLE, Dout=0; a Start pulse during Busy -> ignored, with the frame count unchanged.
